// File: rtl/serializer_pkg.sv
// Shared definitions for the 16-bit parallel-to-serial converter:
// widths, minimum legal length, FSM state type and the length decoder.
package serializer_pkg;

    localparam int DATA_W  = 16;
    localparam int MOD_W   = 4;
    localparam int CNT_W   = 5;
    localparam int MIN_MOD = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // 0 encodes a full 16-bit word; 1 and 2 are not legal lengths.
    function automatic logic len_ok(input logic [MOD_W-1:0] m);
        return (m == '0) || (m >= MOD_W'(MIN_MOD));
    endfunction

    function automatic logic [CNT_W-1:0] len_of(input logic [MOD_W-1:0] m);
        return (m == '0) ? CNT_W'(DATA_W) : {1'b0, m};
    endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: latches a 16-bit word with a length of
// 3..16 bits and shifts the selected bits out MSB-first, one per clock.
// Ports:
//   clk_i          : clock, rising edge
//   srst_i         : asynchronous active-high reset
//   data_i         : parallel word, bit 15 sent first
//   data_val_i     : data_i / data_mod_i valid this cycle
//   data_mod_i     : bits to send (0 = 16, 1 and 2 rejected)
//   ser_data_o     : serial bit (0 when not valid)
//   ser_data_val_o : ser_data_o valid
//   busy_o         : a word offered now would be dropped
module serializer
    import serializer_pkg::*;
(
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_val_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    state_t              state;
    logic [DATA_W-1:0]   shreg;
    logic [CNT_W-1:0]    cnt;

    logic                accept;
    logic [CNT_W-1:0]    len;
    logic                more;

    // busy_o is low both in IDLE and on the last bit, so a word offered
    // in that cycle is loaded on the same edge the old word ends.
    assign accept = data_val_i && !busy_o && len_ok(data_mod_i);
    assign len    = len_of(data_mod_i);
    // cnt counts bits still to present, including the one on ser_data_o
    assign more   = (state == SEND) && (cnt > CNT_W'(1));

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state          <= IDLE;
            shreg          <= '0;
            cnt            <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
        end else if (accept) begin
            state          <= SEND;
            shreg          <= data_i;
            cnt            <= len;
            ser_data_o     <= data_i[DATA_W-1];
            ser_data_val_o <= 1'b1;
            busy_o         <= (len > CNT_W'(1));
        end else if (more) begin
            shreg          <= shreg << 1;
            cnt            <= cnt - CNT_W'(1);
            ser_data_o     <= shreg[DATA_W-2];
            ser_data_val_o <= 1'b1;
            busy_o         <= (cnt > CNT_W'(2));
        end else begin
            state          <= IDLE;
            cnt            <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: a per-cycle scoreboard of expected
// (bit, busy) pairs is filled when a word is offered and drained each cycle.
module tb_serializer;

    logic        clk = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic        data_val_i;
    logic [3:0]  data_mod_i;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    typedef struct {
        logic b;
        logic busy;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        cur_busy = 1'b0;
    logic [31:0] cap;
    int          vcnt;

    serializer dut (
        .clk_i          (clk),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_val_i     (data_val_i),
        .data_mod_i     (data_mod_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: check current outputs, then drive inputs for next edge.
    task automatic tick(input logic v, input logic [15:0] d,
                        input logic [3:0] m, input bit wait_free,
                        output bit done);
        exp_t e;
        logic ev;
        int   n;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ev = 1'b1;
        end else begin
            e.b    = 1'b0;
            e.busy = 1'b0;
            ev     = 1'b0;
        end
        check("val", 32'(ser_data_val_o), 32'(ev));
        check("bit", 32'(ser_data_o), 32'(e.b));
        check("busy", 32'(busy_o), 32'(e.busy));
        if (ser_data_val_o) begin
            cap = {cap[30:0], ser_data_o};
            vcnt++;
        end
        cur_busy   = e.busy;
        done       = wait_free ? !cur_busy : 1'b1;
        data_val_i = wait_free ? (v && !cur_busy) : v;
        data_i     = d;
        data_mod_i = m;
        if (data_val_i && !cur_busy && (m == 4'd0 || m >= 4'd3)) begin
            n = (m == 4'd0) ? 16 : int'(m);
            for (int i = 0; i < n; i++) begin
                e.b    = d[15-i];
                e.busy = (i < n - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        bit dn;
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'h0, 1'b0, dn);
    endtask

    // Offer a word in the first cycle the model says busy_o is low.
    task automatic send_word(input logic [15:0] d, input logic [3:0] m);
        bit dn;
        int k;
        dn = 1'b0;
        k  = 0;
        while (!dn && k < 40) begin
            tick(1'b1, d, m, 1'b1, dn);
            k++;
        end
        if (!dn) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        srst_i = 1'b1;
        #1;
        check("mrst_val", 32'(ser_data_val_o), 32'd0);
        check("mrst_bit", 32'(ser_data_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        cur_busy   = 1'b0;
        data_val_i = 1'b0;
        repeat (2) @(negedge clk);
        srst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit dn;
        logic [15:0] rd;
        logic [3:0]  rm;
        srst_i     = 1'b1;
        data_i     = '0;
        data_val_i = 1'b0;
        data_mod_i = '0;
        cap        = '0;
        vcnt       = 0;
        repeat (3) @(negedge clk);
        check("rst_val", 32'(ser_data_val_o), 32'd0);
        check("rst_bit", 32'(ser_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        srst_i = 1'b0;
        idle(2);

        cap = '0; vcnt = 0;
        send_word(16'h6CF1, 4'd5);
        idle(7);
        check("w5_bits", cap[4:0], 32'b01101);
        check("w5_len", vcnt, 32'd5);

        cap = '0; vcnt = 0;
        send_word(16'h6CF1, 4'd0);
        idle(18);
        check("w16_bits", cap[15:0], 32'h6CF1);
        check("w16_len", vcnt, 32'd16);

        cap = '0; vcnt = 0;
        send_word(16'h8C11, 4'd10);
        send_word(16'hACA9, 4'd3);
        idle(15);
        check("b2b_bits", cap[12:0], 32'b1000110000101);
        check("b2b_len", vcnt, 32'd13);

        cap = '0; vcnt = 0;
        send_word(16'h6CF1, 4'd1);
        idle(3);
        send_word(16'h6CF1, 4'd2);
        idle(3);
        check("inv_len", vcnt, 32'd0);
        send_word(16'hA5F0, 4'd4);
        idle(6);
        check("post_inv_bits", cap[3:0], 32'b1010);
        check("post_inv_len", vcnt, 32'd4);

        cap = '0; vcnt = 0;
        send_word(16'h6CF1, 4'd8);
        repeat (3) tick(1'b1, 16'hFFFF, 4'd6, 1'b0, dn);
        idle(12);
        check("drop_bits", cap[7:0], 32'h6C);
        check("drop_len", vcnt, 32'd8);

        for (int w = 0; w < 100; w++) begin
            rd = 16'($urandom);
            rm = (w == 50) ? 4'd12 : 4'($urandom_range(0, 15));
            send_word(rd, rm);
            if (w == 50) begin
                idle(2);
                do_reset();
            end
            idle($urandom_range(0, 5));
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial converter: captures one 16-bit word with a per-word valid length and shifts the selected bits out MSB-first, one bit per clock. It sits between a word-oriented producer and a single-bit serial sink. `busy_o` provides flow control so words can be issued back-to-back with no idle cycle between them.

## Interface
- Parameters: none; widths fixed (data 16, length 4).
- `clk_i` in 1: single clock; all logic on rising edge.
- `srst_i` in 1: reset, asynchronous, active-high.
- `data_i` in 16: parallel word; bit 15 is sent first.
- `data_val_i` in 1: `data_i`/`data_mod_i` valid this cycle.
- `data_mod_i` in 4: number of bits to send from MSB down; 0 means 16; 1 and 2 invalid.
- `ser_data_o` out 1: current serial bit.
- `ser_data_val_o` out 1: `ser_data_o` valid.
- `busy_o` out 1: high when a new word would be dropped.

## Operation
- Length decode:
  - N = 16 if `data_mod_i` == 0.
  - N = `data_mod_i` for values 3..15.
  - Values 1 and 2: the word is discarded, with no output and no state change.
- Accept condition: `data_val_i` && `busy_o` == 0 && length valid.
  - On an accepted edge: latch `data_i`, load the bit counter with N, and present bit 15.
- Transmission sends `data_i[15]`, `[14]` … `[16-N]`, one bit per cycle.
- Bits below `16-N` are never sent.
- States:
  - IDLE: `ser_data_val_o` = 0, `busy_o` = 0.
  - SEND: `ser_data_val_o` = 1.
    - `busy_o` = 1 while more than one bit remains.
    - `busy_o` = 0 on the last bit.
- End of word: after the last bit, go to IDLE, unless a word is accepted on that same edge; then go to SEND with the new word (seamless).
- `data_val_i` while `busy_o` = 1 is ignored; the word is dropped, with no error flag.
- `ser_data_o` = 0 whenever `ser_data_val_o` = 0.

## Timing
- Reset: all outputs are 0 and the state is IDLE. Assertion mid-word aborts the word immediately.
- Latency: the first bit appears on the same rising edge that samples `data_val_i` = 1 (registered outputs, valid for the following cycle).
- A word of N bits occupies exactly N cycles with `ser_data_val_o` = 1.
  - `busy_o` = 1 for the first N-1 cycles.
  - `busy_o` = 0 for the final cycle.
- A producer that asserts `data_val_i` in the cycle where `busy_o` = 0 gets its first bit in the cycle immediately after the previous word's last bit.
- N = 3 is the shortest word: `busy_o` is high for 2 cycles, then low.
- No combinational path from inputs to outputs.

## Structure
- Shared package `serializer_pkg`:
  - `DATA_W` = 16 and `MOD_W` = 4.
  - `MIN_MOD` = 3.
  - State enum {IDLE, SEND}.
- Single module with a shift register plus a 5-bit remaining-bit counter; no sub-module needed.
- The length decoder may be a function in the package.

## Test plan
- Reset, then `data_i` = 0x6CF1, mod = 5, one-cycle valid:
  - `ser_data_o` = 0,1,1,0,1 over 5 cycles.
  - `busy_o` = 1,1,1,1,0.
  - `ser_data_val_o` is then 0.
- Word 0x6CF1 with mod = 0:
  - All 16 bits are sent MSB-first (0110110011110001).
  - `ser_data_val_o` is high for exactly 16 cycles.
- 0x8C11 mod = 10 followed back-to-back by 0xACA9 mod = 3, each valid asserted in the `busy_o` = 0 cycle:
  - 10 bits 1000110000, then immediately 101.
  - No gap in `ser_data_val_o`.
- Word 0x6CF1 with mod = 1, and word 0x6CF1 with mod = 2:
  - `ser_data_val_o` and `busy_o` stay 0.
  - A following valid word is accepted normally.
- Assert `data_val_i` with 0xFFFF mod = 6 while `busy_o` = 1 mid-word:
  - The current word completes unchanged.
  - The new word is dropped.
- Random: 100 words with random data, random mod, and 0–5 idle cycles between them:
  - Compare bit sequence, length N, and `busy_o` profile against a model.
  - Assert `srst_i` once mid-word: outputs go to 0 immediately.
